// File: rtl/aes_128_pkg.sv
// ---------------------------------------------------------------------------
// aes_128_pkg
// Shared definitions for the AES-128 key RAM writer and its companion reader
// (aes_128_keyram_control): key-set geometry and the writer FSM encoding.
// ---------------------------------------------------------------------------
package aes_128_pkg;

    // Round keys per AES-128 key schedule (rounds 0..10).
    localparam int DEF_NUM_ROUND_KEYS = 11;
    // Each 128-bit round key occupies two 64-bit RAM words.
    localparam int DEF_LENGTH_KEY_SET = 2 * DEF_NUM_ROUND_KEYS;

    localparam int RK_CNT_W   = 4;
    localparam int WR_ADDR_W  = 5;
    localparam int RAM_DATA_W = 64;
    localparam int RK_DATA_W  = 128;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WR_LO  = 3'd2,
        ST_WR_HI  = 3'd3,
        ST_DONE   = 3'd4
    } kw_state_e;

endpackage

// File: rtl/aes_128_keyram_writer.sv
// ---------------------------------------------------------------------------
// aes_128_keyram_writer
// Takes 128-bit round keys from the key expansion engine (round 0 first) and
// writes each as two 64-bit words into the key RAM, low half at the even
// address then high half at the odd address. A full set of NUM_ROUND_KEYS keys
// fills addresses 0..LENGTH_KEY_SET-1, after which key_ready pulses once.
//
// Ports:
//   clk        : clock, all state on rising edge
//   kill_n     : synchronous active-low reset
//   key_start  : one-cycle request to begin a new key set (ignored while busy)
//   rk_valid   : rk_data holds a valid round key
//   rk_data    : 128-bit round key
//   rk_ready   : writer accepts rk_data this cycle (ACCEPT state only)
//   en_wr      : key RAM write strobe
//   wr_addr    : key RAM word address (0 when en_wr is low)
//   ram_in     : key RAM write data   (0 when en_wr is low)
//   key_ready  : one-cycle pulse once the whole set is written
//   busy       : high in every state except IDLE
// ---------------------------------------------------------------------------
module aes_128_keyram_writer
    import aes_128_pkg::*;
#(
    parameter int LENGTH_KEY_SET = DEF_LENGTH_KEY_SET,
    parameter int NUM_ROUND_KEYS = DEF_NUM_ROUND_KEYS
) (
    input  logic                  clk,
    input  logic                  kill_n,
    input  logic                  key_start,
    input  logic                  rk_valid,
    input  logic [RK_DATA_W-1:0]  rk_data,
    output logic                  rk_ready,
    output logic                  en_wr,
    output logic [WR_ADDR_W-1:0]  wr_addr,
    output logic [RAM_DATA_W-1:0] ram_in,
    output logic                  key_ready,
    output logic                  busy
);

    // The reader pairs words 2k/2k+1, so the set length must be exactly two
    // words per round key.
    if (LENGTH_KEY_SET != 2 * NUM_ROUND_KEYS) begin : g_bad_geometry
        $error("LENGTH_KEY_SET must equal 2*NUM_ROUND_KEYS");
    end

    localparam logic [RK_CNT_W-1:0] RK_LAST = RK_CNT_W'(NUM_ROUND_KEYS - 1);

    kw_state_e             state_q,  state_d;
    logic [RK_CNT_W-1:0]   rk_cnt_q, rk_cnt_d;
    logic [RK_DATA_W-1:0]  hold_q,   hold_d;

    always_ff @(posedge clk) begin
        if (!kill_n) begin
            state_q  <= ST_IDLE;
            rk_cnt_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            rk_cnt_q <= rk_cnt_d;
            hold_q   <= hold_d;
        end
    end

    // Outputs are decoded from state only, so nothing on the input side can
    // reach the RAM port combinationally.
    always_comb begin
        state_d   = state_q;
        rk_cnt_d  = rk_cnt_q;
        hold_d    = hold_q;
        rk_ready  = 1'b0;
        en_wr     = 1'b0;
        wr_addr   = '0;
        ram_in    = '0;
        key_ready = 1'b0;
        busy      = 1'b1;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                // rk_valid is deliberately not looked at here; a key offered
                // alongside key_start is taken on the next cycle in ACCEPT.
                if (key_start) begin
                    state_d  = ST_ACCEPT;
                    rk_cnt_d = '0;
                    hold_d   = '0;
                end
            end

            ST_ACCEPT: begin
                rk_ready = 1'b1;
                if (rk_valid) begin
                    hold_d  = rk_data;
                    state_d = ST_WR_LO;
                end
            end

            ST_WR_LO: begin
                en_wr   = 1'b1;
                wr_addr = {rk_cnt_q, 1'b0};
                ram_in  = hold_q[63:0];
                state_d = ST_WR_HI;
            end

            ST_WR_HI: begin
                en_wr   = 1'b1;
                wr_addr = {rk_cnt_q, 1'b1};
                ram_in  = hold_q[127:64];
                if (rk_cnt_q == RK_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d  = ST_ACCEPT;
                    rk_cnt_d = rk_cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                key_ready = 1'b1;
                rk_cnt_d  = '0;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_128_keyram_writer.sv
// ---------------------------------------------------------------------------
// tb_aes_128_keyram_writer
// Drives round-key sets into the writer and compares the RAM write stream,
// key_ready timing and reset behaviour against a reference built from the
// key list: word 2k = key[k][63:0], word 2k+1 = key[k][127:64].
// ---------------------------------------------------------------------------
module tb_aes_128_keyram_writer;

    logic         clk = 1'b0;
    logic         kill_n;
    logic         key_start;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic         rk_ready;
    logic         en_wr;
    logic [4:0]   wr_addr;
    logic [63:0]  ram_in;
    logic         key_ready;
    logic         busy;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    aes_128_keyram_writer dut (
        .clk       (clk),
        .kill_n    (kill_n),
        .key_start (key_start),
        .rk_valid  (rk_valid),
        .rk_data   (rk_data),
        .rk_ready  (rk_ready),
        .en_wr     (en_wr),
        .wr_addr   (wr_addr),
        .ram_in    (ram_in),
        .key_ready (key_ready),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus keys and observations of the most recent run
    logic [127:0] keys [0:10];
    logic [63:0]  ram_m [0:31];
    int           wq_addr [$];
    logic [63:0]  wq_data [$];
    int           kr_cnt;
    int           kr_cyc;
    int           busy_low_cyc;
    int           zero_viol;
    int           kill_out_bad;

    // Reference: count of observed writes that differ from the expected
    // stream for the first n_exp words.
    function automatic int write_errs(input int n_exp);
        int errs = 0;
        logic [63:0] exp_d;
        for (int i = 0; i < n_exp && i < wq_addr.size(); i++) begin
            exp_d = (i % 2 == 1) ? keys[i / 2][127:64] : keys[i / 2][63:0];
            if (wq_addr[i] != i || wq_data[i] !== exp_d) errs++;
        end
        return errs;
    endfunction

    task automatic rand_keys();
        for (int i = 0; i < 11; i++)
            keys[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Runs one key set. gap_key/gap_len: withhold rk_valid for gap_len
    // ready cycles before key gap_key. pulse_key: raise key_start during the
    // high write of that key. kill_addr: assert kill_n=0 right after the
    // write at that address.
    task automatic run_set(input int gap_key, input int gap_len,
                           input int pulse_key, input int kill_addr,
                           output int ks_cyc, output bit timeout);
        int  idx = 0;
        bit  last_fire = 0;
        int  gap_rem = gap_len;
        bit  seen_busy = 0;
        bit  killed = 0;
        wq_addr.delete();
        wq_data.delete();
        kr_cnt = 0; kr_cyc = -1; busy_low_cyc = -1; zero_viol = 0; kill_out_bad = 0;
        timeout = 1;
        @(negedge clk);
        key_start = 1'b1;
        rk_valid  = 1'b1;        // offered with key_start, must not be captured
        rk_data   = ~keys[0];
        ks_cyc    = cyc;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (en_wr === 1'b1) begin
                wq_addr.push_back(int'(wr_addr));
                wq_data.push_back(ram_in);
                ram_m[wr_addr] = ram_in;
            end else if (ram_in !== 64'd0 || wr_addr !== 5'd0) begin
                zero_viol++;
            end
            if (key_ready === 1'b1) begin kr_cnt++; kr_cyc = cyc; end
            key_start = 1'b0;
            if (killed) begin
                if ({rk_ready, en_wr, wr_addr, ram_in, key_ready, busy} !== '0)
                    kill_out_bad++;
                kill_n  = 1'b1;
                timeout = 0;
                break;
            end
            if (busy === 1'b1) seen_busy = 1;
            else if (seen_busy) begin busy_low_cyc = cyc; timeout = 0; break; end
            if (kill_addr >= 0 && en_wr === 1'b1 && int'(wr_addr) == kill_addr) begin
                kill_n = 1'b0; killed = 1;
            end
            if (pulse_key >= 0 && en_wr === 1'b1 && int'(wr_addr) == 2 * pulse_key + 1)
                key_start = 1'b1;
            if (last_fire) idx++;
            rk_data = (idx < 11) ? keys[idx] : 128'd0;
            if (gap_key >= 0 && idx == gap_key && rk_ready === 1'b1 && gap_rem > 0) begin
                rk_valid = 1'b0;
                gap_rem--;
            end else begin
                rk_valid = (idx < 11);
            end
            last_fire = rk_valid && (rk_ready === 1'b1);
        end
        rk_valid  = 1'b0;
        key_start = 1'b0;
    endtask

    task automatic test_reset();
        kill_n = 1'b0; key_start = 1'b1; rk_valid = 1'b1; rk_data = '1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rk_ready, en_wr, wr_addr, ram_in, key_ready, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got rk_ready=%b en_wr=%b addr=%0d ram_in=%h key_ready=%b busy=%b want all 0",
                     rk_ready, en_wr, wr_addr, ram_in, key_ready, busy);
        end
        key_start = 1'b0; rk_valid = 1'b0; kill_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_busy got %b want 0", busy);
        end
    endtask

    task automatic test_idle_valid();
        int bad = 0;
        rk_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rk_data = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (rk_ready !== 1'b0 || en_wr !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b0) bad++;
        end
        rk_valid = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_valid_ignored got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_back_to_back(input bit pattern);
        int ks; bit to; int lb_bad = 0;
        logic [3:0] nib;
        if (pattern) begin
            for (int i = 0; i < 11; i++) begin nib = 4'(i); keys[i] = {32{nib}}; end
        end else rand_keys();
        run_set(-1, 0, -1, -1, ks, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL b2b_timeout got no busy fall want done"); end
        n_checks++;
        if (wq_addr.size() != 22) begin
            n_fail++; $display("FAIL b2b_write_count got %0d want 22", wq_addr.size());
        end
        n_checks++;
        if (write_errs(22) != 0) begin
            n_fail++; $display("FAIL b2b_write_stream got %0d bad words want 0", write_errs(22));
        end
        n_checks++;
        if (kr_cnt != 1 || kr_cyc - ks != 34) begin
            n_fail++; $display("FAIL b2b_key_ready got count=%0d latency=%0d want 1/34", kr_cnt, kr_cyc - ks);
        end
        n_checks++;
        if (busy_low_cyc - ks != 35) begin
            n_fail++; $display("FAIL b2b_busy_low got %0d want 35", busy_low_cyc - ks);
        end
        n_checks++;
        if (zero_viol != 0) begin
            n_fail++; $display("FAIL b2b_idle_bus_zero got %0d nonzero cycles want 0", zero_viol);
        end
        // Reader-side view: even/odd word pair k rebuilds round key k.
        for (int k = 0; k < 11; k++)
            if ({ram_m[2 * k + 1], ram_m[2 * k]} !== keys[k]) lb_bad++;
        n_checks++;
        if (lb_bad != 0) begin
            n_fail++; $display("FAIL b2b_loopback got %0d bad keys want 0", lb_bad);
        end
    endtask

    task automatic test_gap();
        int ks; bit to;
        rand_keys();
        run_set(3, 5, -1, -1, ks, to);
        n_checks++;
        if (to || wq_addr.size() != 22 || write_errs(22) != 0) begin
            n_fail++; $display("FAIL gap_writes got count=%0d errs=%0d timeout=%0b want 22/0/0",
                                wq_addr.size(), write_errs(22), to);
        end
        n_checks++;
        if (kr_cnt != 1 || kr_cyc - ks != 39) begin
            n_fail++; $display("FAIL gap_key_ready got count=%0d latency=%0d want 1/39", kr_cnt, kr_cyc - ks);
        end
        n_checks++;
        if (zero_viol != 0) begin
            n_fail++; $display("FAIL gap_idle_bus_zero got %0d want 0", zero_viol);
        end
    endtask

    task automatic test_start_ignored();
        int ks; bit to;
        rand_keys();
        run_set(-1, 0, 4, -1, ks, to);
        n_checks++;
        if (to || wq_addr.size() != 22 || write_errs(22) != 0) begin
            n_fail++; $display("FAIL restart_ignored_writes got count=%0d errs=%0d timeout=%0b want 22/0/0",
                                wq_addr.size(), write_errs(22), to);
        end
        n_checks++;
        if (kr_cnt != 1 || kr_cyc - ks != 34) begin
            n_fail++; $display("FAIL restart_ignored_key_ready got count=%0d latency=%0d want 1/34",
                                kr_cnt, kr_cyc - ks);
        end
    endtask

    task automatic test_kill();
        int ks; bit to; int late_kr = 0;
        rand_keys();
        run_set(-1, 0, -1, 14, ks, to);
        n_checks++;
        if (to || kill_out_bad != 0) begin
            n_fail++; $display("FAIL kill_outputs got bad=%0d timeout=%0b want 0/0", kill_out_bad, to);
        end
        n_checks++;
        if (wq_addr.size() != 15 || write_errs(15) != 0) begin
            n_fail++; $display("FAIL kill_partial_writes got count=%0d errs=%0d want 15/0",
                                wq_addr.size(), write_errs(15));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (key_ready !== 1'b0 || busy !== 1'b0) late_kr++;
        end
        n_checks++;
        if (kr_cnt != 0 || late_kr != 0) begin
            n_fail++; $display("FAIL kill_no_key_ready got count=%0d late=%0d want 0/0", kr_cnt, late_kr);
        end
    endtask

    initial begin
        kill_n = 1'b1; key_start = 1'b0; rk_valid = 1'b0; rk_data = '0;
        for (int i = 0; i < 32; i++) ram_m[i] = '0;
        test_reset();
        test_idle_valid();
        test_back_to_back(1'b1);
        test_gap();
        test_start_ignored();
        test_kill();
        test_back_to_back(1'b0);   // restart after abandoned set begins at addr 0
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_128_keyram_writer.md
AES_128_KEYRAM_WRITER -- requirements
Module: aes_128_keyram_writer

Interface
REQ-001 SHALL have parameter LENGTH_KEY_SET, default 22, meaning the number of 64-bit RAM words per key set.
REQ-002 SHALL have parameter NUM_ROUND_KEYS, default 11, meaning the number of 128-bit round keys per set; LENGTH_KEY_SET = 2*NUM_ROUND_KEYS.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 kill_n  input  1  reset, synchronous, active-low.
REQ-005 key_start  input  1  one-cycle request to begin writing a new key set.
REQ-006 rk_valid  input  1  round key on rk_data is valid.
REQ-007 rk_data  input  128  round key from the expansion engine, round 0 first.
REQ-008 rk_ready  output  1  writer accepts rk_data this cycle.
REQ-009 en_wr  output  1  key RAM write strobe, one cycle per 64-bit word.
REQ-010 wr_addr  output  5  key RAM word address for the current write.
REQ-011 ram_in  output  64  key RAM write data.
REQ-012 key_ready  output  1  one-cycle pulse: full key set written.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ACCEPT, WR_LO, WR_HI, DONE.
REQ-015 IDLE -> ACCEPT on key_start; round counter rk_cnt (4 bits) and holding register cleared on that transition.
REQ-016 rk_ready SHALL be 1 only in ACCEPT; a transfer occurs when rk_valid & rk_ready; ACCEPT -> WR_LO on transfer, rk_data captured into a 128-bit holding register.
REQ-017 ACCEPT with rk_valid=0 SHALL hold state indefinitely, en_wr=0.
REQ-018 WR_LO: en_wr=1, ram_in=hold[63:0], wr_addr=2*rk_cnt; next state WR_HI.
REQ-019 WR_HI: en_wr=1, ram_in=hold[127:64], wr_addr=2*rk_cnt+1; next state DONE if rk_cnt==NUM_ROUND_KEYS-1, else ACCEPT with rk_cnt+1.
REQ-020 DONE: key_ready=1 for exactly one cycle, en_wr=0; next state IDLE; rk_cnt returns to 0.
REQ-021 Low half SHALL precede high half so the reader's even/odd word pairing rebuilds {high,low}.
REQ-022 en_wr SHALL be asserted exactly LENGTH_KEY_SET times per set, addresses 0..LENGTH_KEY_SET-1 strictly increasing, never wrapping within a set.
REQ-023 Minimum latency: 3 cycles per round key; a set with rk_valid held high completes key_ready 34 cycles after key_start.
REQ-024 key_start SHALL be ignored while busy=1 (no restart, no counter change).
REQ-025 rk_valid SHALL be ignored (no capture) in IDLE, WR_LO, WR_HI, DONE.
REQ-026 When en_wr=0, ram_in and wr_addr SHALL be 0.
REQ-027 Simultaneous key_start and rk_valid in IDLE: only key_start acts; rk_data captured no earlier than the next cycle in ACCEPT.

Reset
REQ-028 kill_n=0 at a clock edge SHALL force state IDLE, rk_cnt=0, holding register=0, and all outputs 0 on the following cycle.
REQ-029 Reset mid-set SHALL abandon the set without asserting key_ready; the next set restarts at wr_addr 0.

Structure
REQ-030 LENGTH_KEY_SET, NUM_ROUND_KEYS, and the FSM state encoding SHALL live in shared package aes_128_pkg, also used by aes_128_keyram_control.
REQ-031 Single flat module; no sub-modules.

Verification
REQ-032 Reset then key_start, 11 back-to-back keys rk_data=128'h{i}_..._{i} (i=0..10) -> 22 en_wr pulses, addr 0..21, ram_in low/high halves in order, key_ready at cycle 34, busy low at 35.
REQ-033 Gap insertion: rk_valid low 5 cycles before key 3 -> rk_ready held, en_wr=0 during gap, addr continues at 6.
REQ-034 key_start pulsed at WR_HI of key 4 -> ignored; set still finishes with 22 writes and one key_ready.
REQ-035 kill_n=0 after key 7 low write (addr 14) -> no key_ready, outputs 0; new key_start restarts at addr 0.
REQ-036 rk_valid=1 in IDLE without key_start for 10 cycles -> rk_ready=0, en_wr=0, no state change.
REQ-037 Loopback with aes_128_keyram_control and 22x64 RAM: key_round_rd for read pair k equals written key k for k=0..10.
